load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the data-mask decoder: consumes its mask_type/ext_type with the ALU-computed address and store data, and runs one access on the word-wide data-memory bus.
- Performs byte-lane alignment, byte-enable generation, store-data replication and load sign/zero extension.
- Detects misaligned and illegal accesses.
- Stalls the single-cycle core until the bus access completes.

Parameters:
- TIMEOUT, 255, bus-wait cycle limit per phase; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  load request, held stable while stall=1
- mem_write  in  1  store request, held stable while stall=1
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- mask_type  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- ext_type  in  1  0 sign-extend, 1 zero-extend; loads only
- rdata  out  32  extended load data; valid only while done=1
- stall  out  1  freeze-core request
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse with done: misaligned, illegal or timeout
- bus_req  out  1  bus request, held until bus_gnt
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted; write complete on the same cycle
- bus_rvalid  in  1  read data valid, arrives at least 1 cycle after gnt
- bus_rdata  in  32  read word

Behaviour:
- Reset values:
  - State IDLE; counter 0.
  - stall=0, done=0, fault=0, rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
- stall (combinational) = (mem_read|mem_write) && state!=DONE.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, request present:
  - Fault conditions:
    - mem_read&&mem_write
    - mask_type=11
    - halfword with addr[0]=1
    - word with addr[1:0]!=0
  - Any fault condition -> DONE with fault=1; no bus activity.
  - Otherwise register bus_addr/bus_be/bus_wdata/bus_we, latch mask_type, ext_type and addr[1:0]; -> REQ.
- Byte enables by offset off=addr[1:0]:
  - byte: 4'b0001<<off.
  - half: 4'b0011<<off.
  - word: 4'b1111.
- Store data:
  - byte: wdata[7:0] replicated x4.
  - half: wdata[15:0] replicated x2.
  - word: unchanged.
- REQ:
  - bus_req=1 and bus fields held stable until bus_gnt.
  - On gnt, bus_req drops the next cycle.
  - Store -> DONE; load -> RESP.
- RESP: on bus_rvalid, extract the lane selected by the latched offset.
  - byte: bus_rdata[8*off+:8].
  - half: bus_rdata[16*off[1]+:16].
  - word: whole word; ext_type ignored.
  - Extend per ext_type, register into rdata, -> DONE.
- DONE:
  - done=1 for exactly one cycle; stall=0, so the core advances.
  - rdata is held until the next load's DONE.
  - -> IDLE.
- Timeout:
  - Counter clears on entry to REQ and to RESP and increments each waiting cycle.
  - When TIMEOUT!=0 and count reaches TIMEOUT: -> DONE with fault=1, bus_req=0, rdata unchanged.
- A bus_rvalid seen outside RESP (late, or post-reset) is ignored.
- Reset mid-access: immediate return to IDLE, bus_req=0, no done pulse; any outstanding response is dropped.
- Back-to-back requests: the next access starts in the IDLE cycle following DONE. Minimum latencies:
  - store: 3 cycles (IDLE, REQ with immediate gnt, DONE).
  - load: 4 cycles (IDLE, REQ, RESP, DONE).

Test Plan:
- Load byte signed: addr=0x1003, mask=00, ext=0, bus_rdata=0x80FF_FFFF -> bus_addr=0x1000, bus_be=4'b1000, rdata=0xFFFF_FF80, done after 4 cycles with gnt immediate and rvalid next cycle.
- Load half unsigned: addr=0x2002, mask=01, ext=1, bus_rdata=0xBEEF_1234 -> bus_be=4'b1100, rdata=0x0000_BEEF, fault=0.
- Store byte: addr=0x0001, wdata=0x1234_56AB, mask=00 -> bus_we=1, bus_be=4'b0010, bus_wdata=0xABAB_ABAB; gnt delayed 3 cycles -> bus fields stable, stall=1 throughout, done 1 cycle after gnt.
- Misaligned word load: addr=0x0006, mask=10 -> bus_req never asserted; done=1 and fault=1 on the 2nd cycle; mask=11 at aligned addr -> same response.
- Timeout: TIMEOUT=4, load with gnt given but rvalid never arriving -> fault pulse 4 cycles after RESP entry, rdata unchanged; a late rvalid afterwards -> no effect.
- Reset asserted in RESP -> next cycle IDLE, bus_req=0, done=0; a stale rvalid then arrives -> ignored; a following aligned word store completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: runs one aligned access per request on a word-wide data bus,
// handling lane alignment, byte enables, store replication and load extension.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  mask_type,
  input  logic        ext_type,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = 32;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mask_q, mask_d;
  logic              ext_q, ext_d;
  logic [1:0]        off_q, off_d;

  logic [31:0]       rdata_d, bus_addr_d, bus_wdata_d;
  logic [3:0]        bus_be_d;
  logic              done_d, fault_d, bus_req_d, bus_we_d;

  logic              req_fault_c;
  logic [3:0]        be_c;
  logic [31:0]       wrep_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [31:0]       load_c;

  // The core is frozen for the whole access except the completion cycle.
  assign stall = (mem_read | mem_write) && (state_q != DONE);

  // Request decode: legality, byte enables and lane-replicated store data.
  always_comb begin
    req_fault_c = 1'b0;
    be_c        = 4'b0000;
    wrep_c      = wdata;
    case (mask_type)
      2'b00: begin
        be_c   = 4'b0001 << addr[1:0];
        wrep_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c        = 4'b0011 << addr[1:0];
        wrep_c      = {2{wdata[15:0]}};
        req_fault_c = addr[0];
      end
      2'b10: begin
        be_c        = 4'b1111;
        req_fault_c = (addr[1:0] != 2'b00);
      end
      default: req_fault_c = 1'b1;
    endcase
    if (mem_read && mem_write) req_fault_c = 1'b1;
  end

  // Load lane selection and sign/zero extension using the latched offset.
  always_comb begin
    case (off_q)
      2'd0:    byte_c = bus_rdata[7:0];
      2'd1:    byte_c = bus_rdata[15:8];
      2'd2:    byte_c = bus_rdata[23:16];
      default: byte_c = bus_rdata[31:24];
    endcase
    half_c = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (mask_q)
      2'b00:   load_c = {{24{byte_c[7] & ~ext_q}}, byte_c};
      2'b01:   load_c = {{16{half_c[15] & ~ext_q}}, half_c};
      default: load_c = bus_rdata;
    endcase
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    ext_d       = ext_q;
    off_d       = off_q;
    rdata_d     = rdata;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    bus_req_d   = 1'b0;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_be_d    = bus_be;
    bus_wdata_d = bus_wdata;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (req_fault_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = be_c;
            bus_wdata_d = wrep_c;
            mask_d      = mask_type;
            ext_d       = ext_type;
            off_d       = addr[1:0];
          end
        end
      end
      REQ: begin
        if (bus_gnt) begin
          if (bus_we) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RESP;
            cnt_d   = '0;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          bus_req_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = load_c;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mask_q    <= 2'b00;
      ext_q     <= 1'b0;
      off_q     <= 2'b00;
      rdata     <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      ext_q     <= ext_d;
      off_q     <= off_d;
      rdata     <= rdata_d;
      done      <= done_d;
      fault     <= fault_d;
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_be    <= bus_be_d;
      bus_wdata <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level timeline model plus per-cycle compare.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk, rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [1:0]  mask_type;
  logic        ext_type;
  logic [31:0] rdata;
  logic        stall, done, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .mask_type(mask_type), .ext_type(ext_type),
    .rdata(rdata), .stall(stall), .done(done), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values for the current cycle, written by the driver.
  logic        chk_en, exp_zero;
  logic        exp_stall, exp_done, exp_fault, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata, last_rdata;
  logic [3:0]  exp_be;
  int          cur_c;

  // Values observed by the compare process for directed literal checks.
  logic [31:0] cap_rdata, cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_fault;
  int          done_at, req_total;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    req_total = 0;
    done_at   = -1;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("done", 32'(done), 32'(exp_done));
        chk("fault", 32'(fault), 32'(exp_fault));
        chk("bus_req", 32'(bus_req), 32'(exp_req));
        if (exp_req) begin
          chk("bus_we", 32'(bus_we), 32'(exp_we));
          chk("bus_addr", bus_addr, exp_addr);
          chk("bus_be", 32'(bus_be), 32'(exp_be));
          chk("bus_wdata", bus_wdata, exp_wdata);
        end
        if (exp_done) chk("rdata", rdata, last_rdata);
        if (exp_zero) begin
          chk("rst_rdata", rdata, 32'h0);
          chk("rst_bus_addr", bus_addr, 32'h0);
          chk("rst_bus_be", 32'(bus_be), 32'h0);
          chk("rst_bus_wdata", bus_wdata, 32'h0);
          chk("rst_bus_we", 32'(bus_we), 32'h0);
        end
        if (bus_req) begin
          req_total++;
          cap_we    = bus_we;
          cap_addr  = bus_addr;
          cap_be    = bus_be;
          cap_wdata = bus_wdata;
        end
        if (done) begin
          cap_rdata = rdata;
          cap_fault = fault;
          done_at   = cur_c;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit stray);
    for (int k = 0; k < n; k++) begin
      step();
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr       = $urandom();
      wdata      = $urandom();
      mask_type  = 2'($urandom_range(0, 3));
      ext_type   = 1'($urandom_range(0, 1));
      bus_gnt    = 1'b0;
      bus_rvalid = stray && ($urandom_range(0, 2) == 0);
      bus_rdata  = $urandom();
      exp_stall  = 1'b0;
      exp_done   = 1'b0;
      exp_fault  = 1'b0;
      exp_req    = 1'b0;
    end
  endtask

  // One core request; g = REQ cycles before gnt, r = RESP cycles before rvalid.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] mt, input logic ex,
                           input int g, input int r, input logic [31:0] word);
    logic        dec_flt, flt, ok_load;
    logic [31:0] v;
    int          req_last, done_c, gnt_c, rv_c;
    dec_flt = (rd && wr) || (mt == 2'b11) || (mt == 2'b01 && a[0]) ||
              (mt == 2'b10 && a[1:0] != 2'b00);
    flt     = dec_flt;
    ok_load = 1'b0;
    if (dec_flt) begin
      req_last = 0;  done_c = 1;
    end else if (g >= TO) begin
      req_last = TO; done_c = TO + 1; flt = 1'b1;
    end else if (wr) begin
      req_last = 1 + g; done_c = 2 + g;
    end else if (r >= TO) begin
      req_last = 1 + g; done_c = 2 + g + TO; flt = 1'b1;
    end else begin
      req_last = 1 + g; done_c = 3 + g + r; ok_load = 1'b1;
    end
    gnt_c = (!dec_flt && g < TO) ? 1 + g : -1;
    rv_c  = ok_load ? 2 + g + r : -1;

    case (mt)
      2'b00: begin
        v = (word >> (8 * a[1:0])) & 32'hFF;
        if (!ex && v >= 32'h80) v = v | 32'hFFFF_FF00;
        exp_be    = 4'(1 << a[1:0]);
        exp_wdata = 32'(wd[7:0]) * 32'h0101_0101;
      end
      2'b01: begin
        v = (word >> (16 * a[1])) & 32'hFFFF;
        if (!ex && v >= 32'h8000) v = v | 32'hFFFF_0000;
        exp_be    = 4'(3 << a[1:0]);
        exp_wdata = 32'(wd[15:0]) * 32'h0001_0001;
      end
      default: begin
        v         = word;
        exp_be    = 4'hF;
        exp_wdata = wd;
      end
    endcase
    exp_addr = a & 32'hFFFF_FFFC;
    exp_we   = wr;

    for (int c = 0; c <= done_c; c++) begin
      step();
      exp_zero   = 1'b0;
      cur_c      = c;
      mem_read   = rd;
      mem_write  = wr;
      addr       = a;
      wdata      = wd;
      mask_type  = mt;
      ext_type   = ex;
      bus_gnt    = (c == gnt_c);
      bus_rvalid = (c == rv_c);
      bus_rdata  = (c == rv_c) ? word : $urandom();
      exp_req    = (c >= 1 && c <= req_last);
      exp_stall  = (c < done_c);
      exp_done   = (c == done_c);
      exp_fault  = (c == done_c) && flt;
      if (c == done_c && ok_load) last_rdata = v;
    end
  endtask

  initial begin
    rst = 1'b1; chk_en = 1'b0; exp_zero = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    mask_type = 2'b00; ext_type = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    exp_stall = 1'b0; exp_done = 1'b0; exp_fault = 1'b0; exp_req = 1'b0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    last_rdata = '0; cur_c = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    step();
    rst = 1'b0;
    idle(2, 1'b1);

    // Signed byte load from lane 3.
    do_access(1, 0, 32'h1003, 32'h0, 2'b00, 1'b0, 0, 0, 32'h80FF_FFFF);
    settle();
    chk("lb_rdata", cap_rdata, 32'hFFFF_FF80);
    chk("lb_bus_addr", cap_addr, 32'h0000_1000);
    chk("lb_bus_be", 32'(cap_be), 32'h8);
    chk("lb_latency", 32'(done_at), 32'd3);
    chk("lb_fault", 32'(cap_fault), 32'h0);

    // Unsigned halfword load from the upper half.
    do_access(1, 0, 32'h2002, 32'h0, 2'b01, 1'b1, 0, 1, 32'hBEEF_1234);
    settle();
    chk("lhu_rdata", cap_rdata, 32'h0000_BEEF);
    chk("lhu_bus_be", 32'(cap_be), 32'hC);
    chk("lhu_fault", 32'(cap_fault), 32'h0);

    // Byte store with grant delayed three cycles.
    begin
      int req_before;
      req_before = req_total;
      do_access(0, 1, 32'h0001, 32'h1234_56AB, 2'b00, 1'b0, 3, 0, 32'h0);
      settle();
      chk("sb_bus_we", 32'(cap_we), 32'h1);
      chk("sb_bus_be", 32'(cap_be), 32'h2);
      chk("sb_bus_wdata", cap_wdata, 32'hABAB_ABAB);
      chk("sb_req_cycles", 32'(req_total - req_before), 32'd4);
      chk("sb_latency", 32'(done_at), 32'd5);
    end

    // Misaligned word and illegal mask: immediate fault, no bus traffic.
    begin
      int req_before;
      req_before = req_total;
      do_access(1, 0, 32'h0006, 32'h0, 2'b10, 1'b0, 0, 0, 32'h0);
      settle();
      chk("mis_fault", 32'(cap_fault), 32'h1);
      chk("mis_latency", 32'(done_at), 32'd1);
      do_access(1, 0, 32'h0008, 32'h0, 2'b11, 1'b0, 0, 0, 32'h0);
      settle();
      chk("ill_fault", 32'(cap_fault), 32'h1);
      chk("ill_latency", 32'(done_at), 32'd1);
      chk("flt_no_req", 32'(req_total - req_before), 32'd0);
    end

    // Response timeout; rdata keeps the previous load value, late rvalid ignored.
    do_access(1, 0, 32'h0100, 32'h0, 2'b10, 1'b0, 0, TO, 32'h5555_AAAA);
    settle();
    chk("to_fault", 32'(cap_fault), 32'h1);
    chk("to_latency", 32'(done_at), 32'd6);
    chk("to_rdata", cap_rdata, 32'h0000_BEEF);
    step();
    mem_read = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    exp_stall = 1'b0; exp_done = 1'b0; exp_fault = 1'b0; exp_req = 1'b0;
    idle(3, 1'b0);

    // Reset while waiting for read data.
    step();
    cur_c = 0; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h40; wdata = 32'h0;
    mask_type = 2'b10; ext_type = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    exp_addr = 32'h40; exp_be = 4'hF; exp_we = 1'b0; exp_wdata = 32'h0;
    exp_req = 1'b0; exp_stall = 1'b1; exp_done = 1'b0; exp_fault = 1'b0;
    step();
    bus_gnt = 1'b1; exp_req = 1'b1;
    step();
    bus_gnt = 1'b0; rst = 1'b1; exp_req = 1'b0;
    step();
    rst = 1'b0; mem_read = 1'b0; bus_rvalid = 1'b1; bus_rdata = $urandom();
    exp_stall = 1'b0; exp_zero = 1'b1; last_rdata = 32'h0;
    step();
    bus_rvalid = 1'b0;
    idle(2, 1'b0);
    exp_zero = 1'b0;
    do_access(0, 1, 32'h0040, 32'hCAFE_F00D, 2'b10, 1'b0, 1, 0, 32'h0);
    settle();
    chk("sw_bus_wdata", cap_wdata, 32'hCAFE_F00D);
    chk("sw_bus_be", 32'(cap_be), 32'hF);
    chk("sw_fault", 32'(cap_fault), 32'h0);
    chk("sw_latency", 32'(done_at), 32'd3);

    // Randomized traffic, back-to-back and with stray responses in the gaps.
    for (int i = 0; i < 300; i++) begin
      int          kind, g, r, msel;
      logic        rd, wr;
      logic [1:0]  mt;
      logic [31:0] a;
      kind = $urandom_range(0, 10);
      rd   = (kind < 5) || (kind == 10);
      wr   = (kind >= 5);
      msel = $urandom_range(0, 9);
      mt   = (msel < 4) ? 2'b00 : (msel < 7) ? 2'b01 : (msel < 9) ? 2'b10 : 2'b11;
      a    = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        if (mt == 2'b01) a[0] = 1'b0;
        if (mt == 2'b10) a[1:0] = 2'b00;
      end
      g = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(0, TO - 1));
      r = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(0, TO - 1));
      do_access(rd, wr, a, $urandom(), mt, 1'($urandom_range(0, 1)), g, r, $urandom());
      idle(int'($urandom_range(0, 2)), 1'b1);
    end

    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
